// File: rtl/cpu_pkg.sv
// Shared definitions for the bit-serial execution stage: datapath width,
// register-file size, instruction field positions, opcodes and FSM states.
package cpu_pkg;

  localparam int DATA_W    = 8;
  localparam int NUM_REGS  = 4;
  localparam int REG_IDX_W = 2;

  // Field positions inside the 12-bit instr word
  localparam int RD_LSB  = 0;
  localparam int RS_LSB  = 2;
  localparam int IMM_LSB = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_OUT  = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Opcodes whose final carry lands in flag_c
  function automatic logic op_sets_c(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) ||
           (op == OP_SHL) || (op == OP_SHR);
  endfunction

  // Opcodes whose result drives flag_z (LDI through ADDI)
  function automatic logic op_sets_z(input logic [3:0] op);
    return (op >= OP_LDI) && (op <= OP_ADDI);
  endfunction

endpackage

// File: rtl/bit_serial_alu.sv
// One-bit combinational ALU slice. The caller owns the carry and
// previous-bit flops and presents one bit position per cycle, LSB first.
module bit_serial_alu
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       a,          // rd bit at the current position
  input  logic       b,          // rs bit at the current position
  input  logic       a_next,     // rd bit one position higher (0 past the MSB)
  input  logic       imm_bit,
  input  logic       carry_in,
  input  logic       prev_bit,   // rd bit one position lower (0 at the LSB)
  output logic       result,
  output logic       carry_out
);

  // Per-opcode bit function; unlisted opcodes pass rd through unchanged
  always_comb begin
    result    = a;
    carry_out = carry_in;
    case (opcode)
      OP_LDI: result = imm_bit;
      OP_ADD: begin
        result    = a ^ b ^ carry_in;
        carry_out = (a & b) | (a & carry_in) | (b & carry_in);
      end
      OP_SUB: begin
        // a + ~b + 1: the carry flop is preset to 1 at accept
        result    = a ^ ~b ^ carry_in;
        carry_out = (a & ~b) | (a & carry_in) | (~b & carry_in);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV: result = b;
      OP_SHL: begin
        // On the last bit, a is the original MSB, which becomes the carry
        result    = prev_bit;
        carry_out = a;
      end
      // Carry was preset to the original LSB at accept and just rides along
      OP_SHR: result = a_next;
      OP_ADDI: begin
        result    = a ^ imm_bit ^ carry_in;
        carry_out = (a & imm_bit) | (a & carry_in) | (imm_bit & carry_in);
      end
      default: begin
        result    = a;
        carry_out = carry_in;
      end
    endcase
  end

endmodule

// File: rtl/bit_serial_exec.sv
// Bit-serial execution stage: accepts one 16-bit instruction from the
// loader, executes it LSB first over DATA_W cycles against a rotating
// register file, then retires it with a one-cycle done pulse.
module bit_serial_exec
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [3:0]        opcode,
  input  logic [11:0]       instr,
  output logic              busy,
  output logic              done,
  output logic              drop_err,
  output logic [DATA_W-1:0] out,
  output logic              flag_c,
  output logic              flag_z
);

  localparam int CNT_W = $clog2(DATA_W);

  state_t                 state_reg;
  logic [3:0]             op_reg;
  logic [REG_IDX_W-1:0]   rd_reg;
  logic [REG_IDX_W-1:0]   rs_reg;
  logic [DATA_W-1:0]      imm_reg;
  logic [CNT_W-1:0]       bitcnt_reg;
  logic                   carry_reg;
  logic                   prev_reg;
  logic                   zacc_reg;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

  logic [DATA_W-1:0]    rd_val;
  logic [DATA_W-1:0]    rs_val;
  logic                 exec_step;
  logic                 last_bit;
  logic                 alu_a_next;
  logic                 alu_res;
  logic                 alu_cout;
  logic                 carry_init;
  logic [REG_IDX_W-1:0] rd_in;

  assign rd_val     = regs_q[rd_reg];
  assign rs_val     = regs_q[rs_reg];
  assign exec_step  = (state_reg == EXEC);
  assign last_bit   = (bitcnt_reg == CNT_W'(DATA_W - 1));
  assign alu_a_next = last_bit ? 1'b0 : rd_val[1];
  assign rd_in      = instr[RD_LSB +: REG_IDX_W];

  // Carry preset at accept: SUB needs the +1, SHR captures the original LSB
  always_comb begin
    carry_init = 1'b0;
    if (opcode == OP_SUB)
      carry_init = 1'b1;
    else if (opcode == OP_SHR)
      carry_init = regs_q[rd_in][0];
  end

  bit_serial_alu u_alu (
    .opcode    (op_reg),
    .a         (rd_val[0]),
    .b         (rs_val[0]),
    .a_next    (alu_a_next),
    .imm_bit   (imm_reg[bitcnt_reg]),
    .carry_in  (carry_reg),
    .prev_bit  (prev_reg),
    .result    (alu_res),
    .carry_out (alu_cout)
  );

  // Register file: rd takes the result bit at the top, rs rotates on its own
  // bit, and rd winning means an rd==rs register rotates only once.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    // One shift register per architectural register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs_q[gi] <= '0;
      end else if (exec_step) begin
        if (rd_reg == REG_IDX_W'(gi))
          regs_q[gi] <= {alu_res, regs_q[gi][DATA_W-1:1]};
        else if (rs_reg == REG_IDX_W'(gi))
          regs_q[gi] <= {regs_q[gi][0], regs_q[gi][DATA_W-1:1]};
      end
    end
  end

  // Control FSM with serial carry/zero state and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      op_reg     <= OP_NOP;
      rd_reg     <= '0;
      rs_reg     <= '0;
      imm_reg    <= '0;
      bitcnt_reg <= '0;
      carry_reg  <= 1'b0;
      prev_reg   <= 1'b0;
      zacc_reg   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      drop_err   <= 1'b0;
      out        <= '0;
      flag_c     <= 1'b0;
      flag_z     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (instr_valid && (state_reg != IDLE))
        drop_err <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (instr_valid) begin
            state_reg  <= EXEC;
            busy       <= 1'b1;
            op_reg     <= opcode;
            rd_reg     <= rd_in;
            rs_reg     <= instr[RS_LSB +: REG_IDX_W];
            imm_reg    <= instr[IMM_LSB +: DATA_W];
            bitcnt_reg <= '0;
            carry_reg  <= carry_init;
            prev_reg   <= 1'b0;
            zacc_reg   <= 1'b0;
          end
        end

        EXEC: begin
          carry_reg  <= alu_cout;
          prev_reg   <= rd_val[0];
          zacc_reg   <= zacc_reg | alu_res;
          bitcnt_reg <= bitcnt_reg + CNT_W'(1);
          if (last_bit) begin
            state_reg <= DONE;
            done      <= 1'b1;
            if (op_sets_c(op_reg))
              flag_c <= alu_cout;
            if (op_sets_z(op_reg))
              flag_z <= ~(zacc_reg | alu_res);
            // rd has made DATA_W-1 rotations; one more restores its value
            if (op_reg == OP_OUT)
              out <= {alu_res, rd_val[DATA_W-1:1]};
          end
        end

        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
